mips32_mem_responder: RTL and testbench

//  Single-port 1024x32 word-addressed memory responder serving the MIPS32 pipeline's two

---
 rtl/mips32_pkg.sv | 20 ++
 rtl/mips32_mem_responder_if.sv | 44 ++++
 rtl/mips32_mem_arbiter.sv | 44 ++++
 rtl/mips32_mem.sv | 116 +++++++++++
 tb/tb_mips32_mem_responder.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 memory responder slice.
//  - DEF_ADDR_W / DEF_DATA_W : default word-address and word widths
//  - state_t                 : responder FSM encoding (IDLE, WAIT, ACCESS, RESP)
//  - owner_t                 : which initiator owns the current access slot
package mips32_pkg;
   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } state_t;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_t;
endpackage

// File: rtl/mips32_mem_responder_if.sv
// Bus bundle between the pipeline initiators / program loader and the
// memory responder.
//  fetch : i_req, i_addr -> i_gnt, i_rvalid, i_rdata
//  data  : d_req, d_we, d_addr, d_wdata -> d_gnt, d_rvalid, d_rdata
//  load  : ld_we, ld_addr, ld_data
//  status: busy
// Handshake: an initiator raises *_req and holds its address (and for data
// also d_we/d_wdata) stable until it sees *_gnt high in a cycle; the grant
// is a one-cycle pulse that consumes the request. Exactly one *_rvalid pulse
// follows each grant, carrying *_rdata, which then holds until the next
// *_rvalid of that port. A store completes with d_rvalid and d_rdata = 0.
interface mips32_mem_responder_if
   import mips32_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_rvalid;
   logic [DATA_W-1:0] i_rdata;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic              ld_we;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              busy;

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ld_we, ld_addr, ld_data,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, busy
   );

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ld_we, ld_addr, ld_data,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, busy
   );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Fixed-priority arbiter (data over fetch) with a starvation guard.
//  clk1, rst : clock, async active-high reset
//  en        : a slot is open this cycle (responder in IDLE/RESP, no loader write)
//  i_req     : fetch request
//  d_req     : data request
//  gnt       : a grant is issued this cycle (combinational)
//  owner     : winner of the grant (valid when gnt=1)
module mips32_mem_arbiter
   import mips32_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic   clk1,
   input  logic   rst,
   input  logic   en,
   input  logic   i_req,
   input  logic   d_req,
   output logic   gnt,
   output owner_t owner
);
   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   logic [SW-1:0] starve_cnt;
   logic          i_wins;

   // Fetch only beats data once data has taken STARVE_MAX slots in a row
   // while fetch was waiting.
   assign i_wins = i_req && (!d_req || (starve_cnt == STARVE_LIM));
   assign gnt    = en && (i_req || d_req);
   assign owner  = i_wins ? OWN_I : OWN_D;

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!i_req) begin
         starve_cnt <= '0;
      end else if (gnt && (owner == OWN_I)) begin
         starve_cnt <= '0;
      end else if (gnt) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/mips32_mem.sv
// This file holds the top-level memory responder.
//  clk1, rst : clock, async active-high reset
//  bus       : slave side of mips32_mem_responder_if (fetch, data, loader, busy)
//  dbg_state : current FSM state, for observation
module mips32_mem_responder
   import mips32_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int WAIT_CYC   = 0,
   parameter int STARVE_MAX = 4
) (
   input  logic                   clk1,
   input  logic                   rst,
   mips32_mem_responder_if.slave  bus,
   output state_t                 dbg_state
);
   localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYC == 0) ? 0 : WAIT_CYC - 1);

   state_t            state;
   logic [3:0]        wait_cnt;
   owner_t            owner_q;
   logic [ADDR_W-1:0] acc_addr;
   logic              acc_we;
   logic [DATA_W-1:0] acc_wdata;
   logic [DATA_W-1:0] mem [0:2**ADDR_W-1];

   logic   slot_open;
   logic   gnt;
   owner_t gnt_owner;

   // A new grant (or a loader write) is only possible between accesses.
   assign slot_open = (state == IDLE) || (state == RESP);

   mips32_mem_arbiter #(.STARVE_MAX(STARVE_MAX)) u_arb (
      .clk1  (clk1),
      .rst   (rst),
      .en    (slot_open && !bus.ld_we),
      .i_req (bus.i_req),
      .d_req (bus.d_req),
      .gnt   (gnt),
      .owner (gnt_owner)
   );

   assign bus.i_gnt = gnt && (gnt_owner == OWN_I);
   assign bus.d_gnt = gnt && (gnt_owner == OWN_D);
   assign dbg_state = state;

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         owner_q      <= OWN_I;
         acc_addr     <= '0;
         acc_we       <= 1'b0;
         acc_wdata    <= '0;
         bus.i_rvalid <= 1'b0;
         bus.d_rvalid <= 1'b0;
         bus.i_rdata  <= '0;
         bus.d_rdata  <= '0;
         bus.busy     <= 1'b0;
      end else begin
         bus.i_rvalid <= 1'b0;
         bus.d_rvalid <= 1'b0;
         case (state)
            IDLE, RESP: begin
               if (gnt) begin
                  owner_q  <= gnt_owner;
                  wait_cnt <= '0;
                  state    <= (WAIT_CYC == 0) ? ACCESS : WAIT;
                  bus.busy <= 1'b1;
                  if (gnt_owner == OWN_D) begin
                     acc_addr  <= bus.d_addr;
                     acc_we    <= bus.d_we;
                     acc_wdata <= bus.d_wdata;
                  end else begin
                     acc_addr  <= bus.i_addr;
                     acc_we    <= 1'b0;
                  end
               end else begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            end
            WAIT: begin
               if (wait_cnt == WAIT_LAST) begin
                  state <= ACCESS;
               end else begin
                  wait_cnt <= wait_cnt + 4'd1;
               end
            end
            ACCESS: begin
               state <= RESP;
               if (owner_q == OWN_D) begin
                  bus.d_rvalid <= 1'b1;
                  bus.d_rdata  <= acc_we ? '0 : mem[acc_addr];
               end else begin
                  bus.i_rvalid <= 1'b1;
                  bus.i_rdata  <= mem[acc_addr];
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Single write port: stores commit at the ACCESS edge, loader writes only
   // while no access is in flight. Contents survive reset.
   always_ff @(posedge clk1) begin
      if ((state == ACCESS) && acc_we) begin
         mem[acc_addr] <= acc_wdata;
      end else if (slot_open && bus.ld_we) begin
         mem[bus.ld_addr] <= bus.ld_data;
      end
   end
endmodule

// File: tb/tb_mips32_mem_responder.sv
// Self-checking bench for mips32_mem_responder.
// dut_a runs with three wait states and carries the scoreboarded traffic;
// dut_b runs with zero wait states for the minimum-latency fetch case.
module tb_mips32_mem_responder;
   import mips32_pkg::*;

   localparam int WAIT_A = 3;
   localparam int TMO    = 300;

   logic clk1 = 1'b0;
   logic rst  = 1'b0;
   always #5 clk1 = ~clk1;

   mips32_mem_responder_if ifa ();
   mips32_mem_responder_if ifb ();
   state_t dbg_a;
   state_t dbg_b;

   mips32_mem_responder #(.WAIT_CYC(WAIT_A), .STARVE_MAX(4)) dut_a (
      .clk1(clk1), .rst(rst), .bus(ifa.slave), .dbg_state(dbg_a));
   mips32_mem_responder #(.WAIT_CYC(0), .STARVE_MAX(4)) dut_b (
      .clk1(clk1), .rst(rst), .bus(ifb.slave), .dbg_state(dbg_b));

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk1) cyc <= cyc + 1;

   // Reference model: what each word of dut_a should hold, in grant order.
   logic [31:0] model_mem [0:1023];
   logic [31:0] i_exp_q[$];
   logic [31:0] d_exp_q[$];
   int          i_due_q[$];
   int          d_due_q[$];
   logic        gnt_log[$];
   logic        log_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk1) begin
      if (rst === 1'b0) begin
         if (ifa.i_rvalid) begin
            if (i_exp_q.size() == 0) chk("i_rvalid_unexpected", 32'd1, 32'd0);
            else begin
               chk("i_rdata", ifa.i_rdata, i_exp_q.pop_front());
               chk("i_latency", 32'(cyc), 32'(i_due_q.pop_front()));
            end
         end
         if (ifa.d_rvalid) begin
            if (d_exp_q.size() == 0) chk("d_rvalid_unexpected", 32'd1, 32'd0);
            else begin
               chk("d_rdata", ifa.d_rdata, d_exp_q.pop_front());
               chk("d_latency", 32'(cyc), 32'(d_due_q.pop_front()));
            end
         end
         if (ifa.i_gnt || ifa.d_gnt) begin
            chk("single_gnt", 32'(ifa.i_gnt & ifa.d_gnt), 32'd0);
            if (log_en) gnt_log.push_back(ifa.d_gnt);
         end
      end
   end

   // ---------------- driver tasks (entered at posedge+1) ----------------
   task automatic ld_a(input logic [9:0] a, input logic [31:0] d);
      ifa.ld_we = 1'b1; ifa.ld_addr = a; ifa.ld_data = d;
      model_mem[a] = d;
      @(posedge clk1); #1;
      ifa.ld_we = 1'b0;
   endtask

   task automatic do_i(input logic [9:0] a);
      bit got = 0;
      ifa.i_req = 1'b1; ifa.i_addr = a;
      for (int n = 0; n < TMO && !got; n++) begin
         @(negedge clk1);
         if (ifa.i_gnt) begin
            got = 1;
            i_exp_q.push_back(model_mem[a]);
            i_due_q.push_back(cyc + WAIT_A + 2);
         end
      end
      if (!got) chk("i_gnt_timeout", 32'd0, 32'd1);
      @(posedge clk1); #1;
      ifa.i_req = 1'b0;
   endtask

   task automatic do_d(input logic [9:0] a, input logic we, input logic [31:0] wd);
      bit got = 0;
      ifa.d_req = 1'b1; ifa.d_addr = a; ifa.d_we = we; ifa.d_wdata = wd;
      for (int n = 0; n < TMO && !got; n++) begin
         @(negedge clk1);
         if (ifa.d_gnt) begin
            got = 1;
            if (we) begin
               d_exp_q.push_back(32'd0);
               model_mem[a] = wd;
            end else begin
               d_exp_q.push_back(model_mem[a]);
            end
            d_due_q.push_back(cyc + WAIT_A + 2);
         end
      end
      if (!got) chk("d_gnt_timeout", 32'd0, 32'd1);
      @(posedge clk1); #1;
      ifa.d_req = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < TMO && (i_exp_q.size() != 0 || d_exp_q.size() != 0); n++) begin
         @(posedge clk1); #1;
      end
      chk("i_queue_empty", 32'(i_exp_q.size()), 32'd0);
      chk("d_queue_empty", 32'(d_exp_q.size()), 32'd0);
      repeat (2) begin @(posedge clk1); #1; end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int t0;
      bit got;
      int a;
      logic [31:0] v;

      ifa.i_req = 0; ifa.i_addr = 0; ifa.d_req = 0; ifa.d_we = 0; ifa.d_addr = 0;
      ifa.d_wdata = 0; ifa.ld_we = 0; ifa.ld_addr = 0; ifa.ld_data = 0;
      ifb.i_req = 0; ifb.i_addr = 0; ifb.d_req = 0; ifb.d_we = 0; ifb.d_addr = 0;
      ifb.d_wdata = 0; ifb.ld_we = 0; ifb.ld_addr = 0; ifb.ld_data = 0;

      #1 rst = 1'b1;
      @(negedge clk1);
      chk("rst_state", 32'(dbg_a), 32'(IDLE));
      chk("rst_busy", 32'(ifa.busy), 32'd0);
      chk("rst_rvalid", 32'({ifa.i_rvalid, ifa.d_rvalid, ifb.i_rvalid, ifb.d_rvalid}), 32'd0);
      chk("rst_rdata", ifa.i_rdata | ifa.d_rdata, 32'd0);
      @(posedge clk1); #1 rst = 1'b0;

      // Minimum-latency fetch on the zero-wait instance.
      ifb.ld_we = 1'b1; ifb.ld_addr = 10'd5; ifb.ld_data = 32'h2800_000A;
      @(posedge clk1); #1;
      ifb.ld_we = 1'b0; ifb.i_req = 1'b1; ifb.i_addr = 10'd5;
      @(negedge clk1);
      chk("b_i_gnt", 32'(ifb.i_gnt), 32'd1);
      t0 = cyc;
      @(posedge clk1); #1 ifb.i_req = 1'b0;
      got = 0;
      for (int k = 0; k < 10 && !got; k++) begin
         @(negedge clk1);
         if (ifb.i_rvalid) begin
            got = 1;
            chk("b_latency", 32'(cyc - t0), 32'd2);
            chk("b_rdata", ifb.i_rdata, 32'h2800_000A);
         end
      end
      if (!got) chk("b_rvalid_timeout", 32'd0, 32'd1);
      @(posedge clk1); #1;

      // Preload every word of dut_a through the loader.
      for (int k = 0; k < 1024; k++) ld_a(10'(k), $urandom());

      // Store then load the same word.
      do_d(10'd12, 1'b1, 32'hDEAD_BEEF);
      do_d(10'd12, 1'b0, 32'h0);
      drain();

      // Top of memory then wrap to word 0.
      do_i(10'd1023);
      a = 1024;
      do_i(a[9:0]);
      drain();

      // Loader write collides with a fetch request in IDLE.
      v = $urandom();
      ifa.ld_we = 1'b1; ifa.ld_addr = 10'd40; ifa.ld_data = v; model_mem[40] = v;
      ifa.i_req = 1'b1; ifa.i_addr = 10'd40;
      @(negedge clk1);
      chk("ld_blocks_gnt", 32'(ifa.i_gnt | ifa.d_gnt), 32'd0);
      @(posedge clk1); #1 ifa.ld_we = 1'b0;
      @(negedge clk1);
      chk("ld_then_i_gnt", 32'(ifa.i_gnt), 32'd1);
      if (ifa.i_gnt) begin
         i_exp_q.push_back(model_mem[40]);
         i_due_q.push_back(cyc + WAIT_A + 2);
      end
      @(posedge clk1); #1 ifa.i_req = 1'b0;
      drain();

      // Both ports held busy: data may take four slots, then fetch.
      log_en = 1'b1;
      fork
         begin
            for (int k = 0; k < 4; k++) do_i(10'($urandom_range(0, 1023)));
         end
         begin
            for (int k = 0; k < 16; k++)
               do_d(10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)), $urandom());
         end
      join
      drain();
      log_en = 1'b0;
      chk("starve_gnt_count", 32'(gnt_log.size()), 32'd20);
      for (int k = 0; k < 20 && k < gnt_log.size(); k++)
         chk($sformatf("starve_gnt_%0d", k), 32'(gnt_log[k]), (k % 5 == 4) ? 32'd0 : 32'd1);

      // Random mixed traffic over a small data window to force reuse.
      fork
         begin
            for (int k = 0; k < 30; k++) begin
               do_i(10'($urandom_range(0, 1023)));
               repeat ($urandom_range(0, 3)) begin @(posedge clk1); #1; end
            end
         end
         begin
            for (int k = 0; k < 30; k++) begin
               do_d(10'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom());
               repeat ($urandom_range(0, 3)) begin @(posedge clk1); #1; end
            end
         end
      join
      drain();

      // Reset during the wait phase of a store: nothing is written or returned.
      ld_a(10'd7, 32'h1);
      ifa.d_req = 1'b1; ifa.d_we = 1'b1; ifa.d_addr = 10'd7; ifa.d_wdata = $urandom();
      @(negedge clk1);
      chk("abort_d_gnt", 32'(ifa.d_gnt), 32'd1);
      @(posedge clk1); #1;
      ifa.d_req = 1'b0; ifa.d_we = 1'b0;
      rst = 1'b1;
      @(negedge clk1);
      chk("abort_state", 32'(dbg_a), 32'(IDLE));
      chk("abort_busy", 32'(ifa.busy), 32'd0);
      chk("abort_outputs", 32'({ifa.i_gnt, ifa.d_gnt, ifa.i_rvalid, ifa.d_rvalid}), 32'd0);
      chk("abort_rdata", ifa.i_rdata | ifa.d_rdata, 32'd0);
      @(posedge clk1); #1 rst = 1'b0;
      repeat (10) begin @(posedge clk1); #1; end
      do_d(10'd7, 1'b0, 32'h0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
